// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath: opcodes, bus widths and status-flag bit positions.
package alu_pkg;

    localparam int RW = 13;
    localparam int SW = 4;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_MOD  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1000;
    localparam logic [3:0] OP_NAND = 4'b1001;
    localparam logic [3:0] OP_SHL  = 4'b1010;
    localparam logic [3:0] OP_ROL  = 4'b1011;
    localparam logic [3:0] OP_SHR  = 4'b1100;
    localparam logic [3:0] OP_ROR  = 4'b1101;
    localparam logic [3:0] OP_INC  = 4'b1110;
    localparam logic [3:0] OP_DEC  = 4'b1111;

    localparam int F_ZERO  = 0;
    localparam int F_CARRY = 1;
    localparam int F_NEG   = 2;
    localparam int F_DZ    = 3;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational status-flag generator for ALU results; also sanitises divide-by-zero results.
module alu_flag_gen
    import alu_pkg::*;
(
    input  logic [SW-1:0] sel,
    input  logic [7:0]    b,
    input  logic [RW-1:0] result,
    output logic [RW-1:0] stored_result,
    output logic [3:0]    flags
);

    logic dz;

    always_comb begin
        dz            = ((sel == OP_DIV) || (sel == OP_MOD)) && (b == 8'd0);
        // The ALU output is undefined on divide-by-zero; store a clean zero instead.
        stored_result = dz ? '0 : result;
        flags         = '0;
        flags[F_DZ]   = dz;
        if ((sel == OP_ADD) || (sel == OP_SHL) || (sel == OP_ROL) || (sel == OP_INC))
            flags[F_CARRY] = result[8];
        if ((sel == OP_SUB) || (sel == OP_DEC))
            flags[F_NEG] = result[RW-1];
        flags[F_ZERO] = (stored_result == '0);
    end

endmodule

// File: rtl/alu_result_fifo.sv
// Result buffer behind the ALU: tags each result with flags and queues it on a valid/ready port.
module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int RW    = alu_pkg::RW,
    parameter int SW    = alu_pkg::SW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SW-1:0]            in_sel,
    input  logic [7:0]               in_b,
    input  logic [RW-1:0]            in_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RW-1:0]            out_result,
    output logic [SW-1:0]            out_sel,
    output logic [3:0]               out_flags,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow_err,
    input  logic                     clear_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [RW-1:0] mem_result [DEPTH];
    logic [SW-1:0] mem_sel    [DEPTH];
    logic [3:0]    mem_flags  [DEPTH];

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [RW-1:0] wr_result;
    logic [3:0]    wr_flags;

    alu_flag_gen u_flag_gen (
        .sel           (in_sel),
        .b             (in_b),
        .result        (in_result),
        .stored_result (wr_result),
        .flags         (wr_flags)
    );

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && !full;
    assign pop       = !empty && out_ready;

    // Control state; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (in_valid && full)
                overflow_err <= 1'b1;
            else if (clear_err)
                overflow_err <= 1'b0;
        end
    end

    // Storage is not reset; reads are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_result[wptr] <= wr_result;
            mem_sel[wptr]    <= in_sel;
            mem_flags[wptr]  <= wr_flags;
        end
    end

    assign out_result = empty ? '0 : mem_result[rptr];
    assign out_sel    = empty ? '0 : mem_sel[rptr];
    assign out_flags  = empty ? '0 : mem_flags[rptr];

endmodule
